// File: rtl/seg_scan8.sv
// seg_scan8: eight-digit multiplexed BCD seven-segment scanner.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   dig0_i..dig7_i BCD digits, dig0 least significant
//   load_i         captures the digits and dp_mask_i into the hold registers
//   dp_mask_i      bit i lights the decimal point of digit i
//   blank_lz_i     enables leading-zero blanking (live input, not held)
//   an_o           active-low anode select, bit i drives digit i
//   seg_o          active-low cathodes {g,f,e,d,c,b,a}
//   dp_o           active-low decimal-point cathode
//   scan_tick_o    one-cycle pulse after the scan index wraps 7 -> 0
//
// Every output is registered from the pre-edge prescaler, index and hold
// registers, so the display trails the scan state by one cycle.
module seg_scan8 #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig0_i,
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig2_i,
    input  logic [3:0] dig3_i,
    input  logic [3:0] dig4_i,
    input  logic [3:0] dig5_i,
    input  logic [3:0] dig6_i,
    input  logic [3:0] dig7_i,
    input  logic       load_i,
    input  logic [7:0] dp_mask_i,
    input  logic       blank_lz_i,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       scan_tick_o
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PLast = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   hold_q, hold_d;
    logic [7:0]    dpm_q, dpm_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          last;
    logic          blank;
    logic [3:0]    cur;
    logic [6:0]    seg_dec;
    logic [7:0]    zero_from;  // bit i: held digits i..7 are all zero
    logic          run;

    always_comb begin
        last    = (presc_q == PLast);
        presc_d = last ? '0 : presc_q + PW'(1);
        idx_d   = last ? idx_q + 3'd1 : idx_q;
        hold_d  = load_i ? {dig7_i, dig6_i, dig5_i, dig4_i, dig3_i, dig2_i, dig1_i, dig0_i}
                         : hold_q;
        dpm_d   = load_i ? dp_mask_i : dpm_q;

        run       = 1'b1;
        zero_from = '0;
        for (int i = 7; i >= 0; i--) begin
            run          = run && (hold_q[4*i +: 4] == 4'd0);
            zero_from[i] = run;
        end

        cur   = hold_q[{idx_q, 2'b00} +: 4];
        blank = blank_lz_i && (idx_q != 3'd0) && zero_from[idx_q];

        seg_dec = 7'b0111111;  // dash for non-BCD codes
        case (cur)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase

        // Last prescaler cycle of each slot is anode dead-time.
        an_d   = (last || blank) ? 8'hFF : ~(8'h01 << idx_q);
        seg_d  = blank ? 7'h7F : seg_dec;
        dp_d   = (last || blank) ? 1'b1 : ~dpm_q[idx_q];
        tick_d = last && (idx_q == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            dpm_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            dpm_q   <= dpm_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign scan_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan8.sv
// Scoreboard bench for seg_scan8 with REFRESH_DIV=4.
// The driver pushes the expected output for each clock edge; the monitor pops
// and compares one cycle-tuple after each edge, and checks the asynchronous
// dark state whenever rst_n falls.
module tb_seg_scan8;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] digs;
    logic        load;
    logic [7:0]  dpm;
    logic        blz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;

    seg_scan8 #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dig0_i     (digs[3:0]),
        .dig1_i     (digs[7:4]),
        .dig2_i     (digs[11:8]),
        .dig3_i     (digs[15:12]),
        .dig4_i     (digs[19:16]),
        .dig5_i     (digs[23:20]),
        .dig6_i     (digs[27:24]),
        .dig7_i     (digs[31:28]),
        .load_i     (load),
        .dp_mask_i  (dpm),
        .blank_lz_i (blz),
        .an_o       (an),
        .seg_o      (seg),
        .dp_o       (dp),
        .scan_tick_o(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Model state: edges since reset release, and held values.
    int          k;
    logic [31:0] m_hold;
    logic [7:0]  m_dpm;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Called at a negedge: drive inputs for the next posedge, push its
    // expected output, then advance to the following negedge.
    task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] m,
                        input logic b);
        exp_t        e;
        int          slot;
        logic        dead;
        logic        blank;
        logic [31:0] above;
        load  = ld;
        digs  = d;
        dpm   = m;
        blz   = b;
        slot  = (k / DIV) % 8;
        dead  = (k % DIV) == DIV - 1;
        above = m_hold >> (4 * slot);
        blank = b && (slot != 0) && (above == 32'd0);
        e.an   = (dead || blank) ? 8'hFF : ~(8'h01 << slot);
        e.seg  = blank ? 7'h7F : dec(above[3:0]);
        e.dp   = (dead || blank) ? 1'b1 : ~m_dpm[slot];
        e.tick = (k % (8 * DIV)) == (8 * DIV - 1);
        sb.push_back(e);
        if (ld) begin
            m_hold = d;
            m_dpm  = m;
        end
        k++;
        @(negedge clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!clk && !rst_n) begin
                #1;
                checks++;
                if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || tick !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_dark t=%0t got an=%h seg=%b dp=%b tick=%b want an=ff seg=1111111 dp=1 tick=0",
                             $time, an, seg, dp, tick);
                end
            end else if (clk) begin
                #1;
                cyc++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (an !== e.an || seg !== e.seg || dp !== e.dp || tick !== e.tick) begin
                        errors++;
                        $display("FAIL scan cyc=%0d got an=%h seg=%b dp=%b tick=%b want an=%h seg=%b dp=%b tick=%b",
                                 cyc, an, seg, dp, tick, e.an, e.seg, e.dp, e.tick);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b1;
        load   = 1'b0;
        digs   = '0;
        dpm    = '0;
        blz    = 1'b0;
        k      = 0;
        m_hold = '0;
        m_dpm  = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Digits 8..1, no blanking: FE,FE,FE,FF,FD,... with a tick at 32.
        step(1'b1, 32'h87654321, 8'h00, 1'b0);
        repeat (35) step(1'b0, 32'h0, 8'h00, 1'b0);

        // 00000042 with blanking: only slots 0 and 1 lit, tick every 32.
        step(1'b1, 32'h00000042, 8'h00, 1'b1);
        repeat (65) step(1'b0, 32'h0, 8'h00, 1'b1);

        // All zero with blanking: only digit 0 lit.
        step(1'b1, 32'h00000000, 8'h00, 1'b1);
        repeat (31) step(1'b0, 32'h0, 8'h00, 1'b1);

        // Non-BCD dash on slot 3, decimal point on slot 2.
        step(1'b1, 32'h0000C000, 8'h04, 1'b0);
        repeat (35) step(1'b0, 32'h0, 8'h00, 1'b0);

        // Load on the slot 2->3 advance edge.
        while (k % 32 != 11) step(1'b0, 32'h0, 8'h00, 1'b0);
        step(1'b1, 32'h00005000, 8'h00, 1'b0);
        repeat (8) step(1'b0, 32'h0, 8'h00, 1'b0);

        // blank_lz toggled every cycle, no hold register on it.
        repeat (32) step(1'b0, 32'h0, 8'h00, logic'(k % 2));

        // Asynchronous reset in the middle of slot 5.
        while (k % 32 != 22) step(1'b0, 32'h0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        k      = 0;
        m_hold = '0;
        m_dpm  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step(1'b0, 32'h0, 8'h00, 1'b0);
        step(1'b1, 32'h00000007, 8'h01, 1'b1);
        repeat (12) step(1'b0, 32'h0, 8'h00, 1'b1);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan8.md
SEG_SCAN8 -- requirements
Module: seg_scan8

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports dig0..dig7, input, 4 bits each: BCD digits, dig0 least significant, dig7 most significant.
REQ-005 The block SHALL have port load, input, 1 bit: captures dig0..dig7 and dp_mask into the hold registers.
REQ-006 The block SHALL have port dp_mask, input, 8 bits: bit i set lights the decimal point on digit i.
REQ-007 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-008 The block SHALL have port an, output, 8 bits, active-low: anode select, bit i drives digit i.
REQ-009 The block SHALL have port seg, output, 7 bits, active-low: cathodes, order {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp, output, 1 bit, active-low: decimal-point cathode.
REQ-011 The block SHALL have port scan_tick, output, 1 bit: one-cycle pulse each time the scan index wraps from 7 to 0.

Function
REQ-012 The block SHALL capture all eight digits and dp_mask in one cycle at the first clk edge where load=1; the hold registers SHALL be unchanged while load=0.
REQ-013 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; scan index idx (3 bits) SHALL increment on the edge where the prescaler equals REFRESH_DIV-1, wrapping from 7 to 0.
REQ-014 All outputs SHALL be registered and SHALL reflect the pre-edge idx, prescaler and hold-register values, giving 1 cycle of latency.
REQ-015 Anode drive: an SHALL be ~(1<<idx), except an=8'hFF when the prescaler equals REFRESH_DIV-1 (one cycle of dead-time per slot) or when the digit is blanked.
REQ-016 Decode, for seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; values 10-15 SHALL display 0111111 (dash).
REQ-017 Blanking: when blank_lz=1, digit i (i≥1) SHALL be blanked if held digits i..7 are all zero; digit 0 SHALL never be blanked.
REQ-018 A blanked slot SHALL drive an=8'hFF, seg=7'h7F and dp=1; slot timing SHALL be unaffected.
REQ-019 dp SHALL be ~held_dp_mask[idx], forced to 1 during dead-time or blanking.
REQ-020 scan_tick SHALL be 1 for exactly the one cycle following the edge where idx wraps 7 to 0, and 0 otherwise.
REQ-021 Data loaded on the same edge as an idx advance SHALL appear on the slot that starts at that edge, one cycle later at the outputs.
REQ-022 Changes to blank_lz SHALL take effect on the next output register update, with no hold register.

Reset
REQ-023 While rst_n=0 the block SHALL force: an=8'hFF, seg=7'h7F, dp=1, scan_tick=0, idx=0, prescaler=0, held digits=0, held dp_mask=0.
REQ-024 Reset assertion SHALL take effect immediately, asynchronously, including mid-slot; after deassertion, scanning SHALL restart at digit 0 with a full slot.

Verification (REFRESH_DIV=4)
REQ-025 Reset release, load digits 8,7,6,5,4,3,2,1 (dig7..dig0), blank_lz=0 -> an cycles FE,FE,FE,FF,FD,..., with seg=1111001 during the FE slot and seg=0000000 during the 7F slot.
REQ-026 Load value 00000042, blank_lz=1 -> only the an=FE (seg 0100100) and an=FD (seg 0011001) slots are lit; slots 2-7 show an=FF; scan_tick pulses every 32 cycles.
REQ-027 All digits 0, blank_lz=1 -> digit 0 shows 1000000, all other slots are dark.
REQ-028 dig3=4'hC, dp_mask=8'h04 -> slot 3 shows seg 0111111; slot 2 shows dp=0 in its three lit cycles; dp=1 in all other slots.
REQ-029 rst_n pulsed low mid-slot 5 -> outputs go dark immediately without waiting for clk; after release the first lit anode is FE.
REQ-030 load asserted in the same cycle as the slot 2→3 advance -> slot 3 shows the new digit with no old-value glitch.
